// File: rtl/jk_cnt_pkg.sv
// ============================================================================
// jk_cnt_pkg : mode encodings and JK next-state helper for jk_mod_counter
// Revision   : 1.0
// ============================================================================
`default_nettype none

package jk_cnt_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_HOLD = 2'b00;
  localparam mode_t MODE_UP   = 2'b01;
  localparam mode_t MODE_DOWN = 2'b10;
  localparam mode_t MODE_JK   = 2'b11;

  // Characteristic equation of a JK flip-flop.
  function automatic logic jk_next(input logic q, input logic j, input logic k);
    return (j & ~q) | (~k & q);
  endfunction

endpackage

`default_nettype wire

// File: rtl/jk_cell.sv
// ============================================================================
// jk_cell  : one-bit JK flip-flop, synchronous active-low reset, clock enable
// Revision : 1.0
// ============================================================================
`default_nettype none

module jk_cell
  import jk_cnt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    if (ce) begin
      q_d = jk_next(q_q, j, k);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

`default_nettype wire

// File: rtl/jk_mod_counter.sv
// ============================================================================
// jk_mod_counter : modulo up/down counter, loadable register and per-bit JK
//                  register built from WIDTH jk_cell instances.
// Option         : JK_CNT_SAT_EN - saturate at the limits instead of wrapping.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module jk_mod_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn,
  output logic             tc
);

  if ((WIDTH < 1) || (WIDTH > 16) || (MODULUS < 2) || (MODULUS > (2 ** WIDTH))) begin : g_param_check
    $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
  end

  localparam logic [WIDTH-1:0] c_mod_max = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   c_modulus = (WIDTH + 1)'(MODULUS);

  logic [WIDTH-1:0] w_q;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_up_val;
  logic [WIDTH-1:0] w_down_val;
  logic [WIDTH-1:0] w_j;
  logic [WIDTH-1:0] w_k;
  logic             w_ce;

  assign w_load_val = ({1'b0, d} >= c_modulus) ? c_mod_max : d;

  // Count targets; anything above c_mod_max only arises from JK mode.
  always_comb begin
    w_up_val = w_q + WIDTH'(1);
    if (w_q >= c_mod_max) begin
`ifdef JK_CNT_SAT_EN
      w_up_val = c_mod_max;
`else
      w_up_val = '0;
`endif
    end
  end

  always_comb begin
    w_down_val = w_q - WIDTH'(1);
    if (w_q > c_mod_max) begin
      w_down_val = c_mod_max;
    end else if (w_q == '0) begin
`ifdef JK_CNT_SAT_EN
      w_down_val = '0;
`else
      w_down_val = c_mod_max;
`endif
    end
  end

  // Counting drives J=K=toggle on exactly the bits that must change.
  always_comb begin
    w_ce = 1'b1;
    w_j  = '0;
    w_k  = '0;
    if (load) begin
      w_j = w_load_val;
      w_k = ~w_load_val;
    end else if (!en) begin
      w_ce = 1'b0;
    end else begin
      case (mode)
        MODE_HOLD: w_ce = 1'b0;
        MODE_UP: begin
          w_j = w_q ^ w_up_val;
          w_k = w_q ^ w_up_val;
        end
        MODE_DOWN: begin
          w_j = w_q ^ w_down_val;
          w_k = w_q ^ w_down_val;
        end
        MODE_JK: begin
          w_j = j;
          w_k = k;
        end
      endcase
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    jk_cell u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .ce    (w_ce),
      .j     (w_j[i]),
      .k     (w_k[i]),
      .q     (w_q[i])
    );
  end

  assign q  = w_q;
  assign qn = ~w_q;
  assign tc = en & ~load & (((mode == MODE_UP) & (w_q == c_mod_max)) |
                            ((mode == MODE_DOWN) & (w_q == '0)));

endmodule

`default_nettype wire

// File: tb/tb_jk_mod_counter.sv
// ============================================================================
// tb_jk_mod_counter : directed bench with a per-cycle arithmetic reference model
// Revision          : 1.0
// ============================================================================
`default_nettype none

module tb_jk_mod_counter;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [1:0]   mode;
  logic         load;
  logic [W-1:0] d;
  logic [W-1:0] j;
  logic [W-1:0] k;
  logic [W-1:0] q;
  logic [W-1:0] qn;
  logic         tc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  jk_mod_counter #(.WIDTH(W), .MODULUS(M)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .mode  (mode),
    .load  (load),
    .d     (d),
    .j     (j),
    .k     (k),
    .q     (q),
    .qn    (qn),
    .tc    (tc)
  );

  // Reference model: plain integer arithmetic on the counter value.
  int m_q     = 0;
  bit m_valid = 1'b0;

  function automatic int jk_model(input int cur, input logic [W-1:0] jj, input logic [W-1:0] kk);
    int r;
    r = 0;
    for (int i = 0; i < W; i++) begin
      case ({jj[i], kk[i]})
        2'b00:   r = r | (((cur >> i) & 1) << i);
        2'b01:   r = r;
        2'b10:   r = r | (1 << i);
        default: r = r | ((((cur >> i) & 1) ^ 1) << i);
      endcase
    end
    return r;
  endfunction

  function automatic int model_tc();
    if (en && !load && ((mode == 2'b01 && m_q == M - 1) || (mode == 2'b10 && m_q == 0)))
      return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_q     <= 0;
      m_valid <= 1'b1;
    end else if (load) begin
      m_q <= (int'(d) >= M) ? M - 1 : int'(d);
    end else if (en) begin
      case (mode)
`ifdef JK_CNT_SAT_EN
        2'b01: m_q <= (m_q >= M - 1) ? M - 1 : m_q + 1;
        2'b10: m_q <= (m_q > M - 1) ? M - 1 : ((m_q == 0) ? 0 : m_q - 1);
`else
        2'b01: m_q <= (m_q >= M - 1) ? 0 : m_q + 1;
        2'b10: m_q <= (m_q > M - 1) ? M - 1 : ((m_q == 0) ? M - 1 : m_q - 1);
`endif
        2'b11: m_q <= jk_model(m_q, j, k);
        default: m_q <= m_q;
      endcase
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_q", int'(q), m_q);
      check("model_qn", int'(qn), (2 ** W - 1) - m_q);
      check("model_tc", int'(tc), model_tc());
    end
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; load = 1'b1; d = 4'd5; en = 1'b0; mode = 2'b00; j = '0; k = '0;
    tick();
    tick();
    check("rst_q", int'(q), 0);
    check("rst_qn", int'(qn), 15);
    check("rst_tc", int'(tc), 0);

    rst_n = 1'b1; load = 1'b0; en = 1'b1; mode = 2'b01;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n == 9) begin
        check("up9_q", int'(q), 9);
        check("up9_tc", int'(tc), 1);
      end
    end
`ifdef JK_CNT_SAT_EN
    check("up_end_q", int'(q), 9);
    check("up_end_tc", int'(tc), 1);
`else
    check("up_end_q", int'(q), 2);
    check("up_end_tc", int'(tc), 0);
`endif

    load = 1'b1; d = 4'd0;
    tick();
    check("ld0_q", int'(q), 0);
    check("ld0_tc", int'(tc), 0);
    load = 1'b0; mode = 2'b10;
    #1;
    check("dn0_tc_now", int'(tc), 1);
    tick();
`ifdef JK_CNT_SAT_EN
    check("dn_wrap_q", int'(q), 0);
`else
    check("dn_wrap_q", int'(q), 9);
`endif
    tick();
    tick();
    en = 1'b0;
    #1;
    check("en0_tc_now", int'(tc), 0);
    repeat (3) tick();
`ifdef JK_CNT_SAT_EN
    check("en0_q", int'(q), 0);
`else
    check("en0_q", int'(q), 7);
`endif
    en = 1'b1;
    repeat (7) tick();
    check("dn_zero_q", int'(q), 0);
    check("dn_zero_tc", int'(tc), 1);

    mode = 2'b00;
    repeat (2) tick();
    check("hold_q", int'(q), 0);
    check("hold_tc", int'(tc), 0);

    load = 1'b1; d = 4'hC; en = 1'b0;
    tick();
    check("clamp_q", int'(q), 9);
    d = 4'd3; rst_n = 1'b0;
    tick();
    check("rst_pri_q", int'(q), 0);
    rst_n = 1'b1; d = 4'd5;
    tick();
    check("ld_en0_q", int'(q), 5);

    load = 1'b0; en = 1'b1; mode = 2'b11; j = 4'b1100; k = 4'b1010;
    tick();
    check("jk_q", int'(q), 13);
    check("jk_tc", int'(tc), 0);
    mode = 2'b01;
    #1;
    check("oor_tc_now", int'(tc), 0);
    tick();
`ifdef JK_CNT_SAT_EN
    check("oor_up_q", int'(q), 9);
`else
    check("oor_up_q", int'(q), 0);
`endif
    load = 1'b1; d = 4'd5;
    tick();
    load = 1'b0; mode = 2'b11;
    tick();
    check("jk2_q", int'(q), 13);
    mode = 2'b10;
    tick();
    check("oor_dn_q", int'(q), 9);

    load = 1'b1; d = 4'd1;
    tick();
    load = 1'b0; mode = 2'b11; j = 4'hF; k = 4'hF;
    tick();
    check("jk_toggle_q", int'(q), 14);
    j = 4'h0;
    tick();
    check("jk_clear_q", int'(q), 0);

    load = 1'b1; d = 4'd6;
    tick();
    load = 1'b0; mode = 2'b01; rst_n = 1'b0;
    tick();
    check("mid_rst_q", int'(q), 0);
    rst_n = 1'b1;
    tick();
    check("mid_rst_up_q", int'(q), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
